// File: rtl/bcd2binary_seq.sv
// Sequential BCD-to-binary converter.
// Reverse double-dabble: one right shift plus a nibble correction per clock.
module bcd2binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic            err_q, err_d;

  logic                  bad;
  logic [BW+BIN_W-1:0]   sh_all;
  logic [BW-1:0]         sh_bcd;
  logic [BIN_W-1:0]      sh_acc;
  logic [BW-1:0]         fix_bcd;

  // Flag any operand nibble outside 0..9.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One iteration: combined right shift, then -3 on nibbles >= 8.
  always_comb begin
    sh_all  = {bcd_q, acc_q} >> 1;
    sh_bcd  = sh_all[BW+BIN_W-1:BIN_W];
    sh_acc  = sh_all[BIN_W-1:0];
    fix_bcd = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8)
        fix_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          acc_d = '0;
          if (bad) begin
            state_d = S_DONE;
            cnt_d   = '0;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = CW'(BIN_W);
          end
        end
      end
      S_SHIFT: begin
        bcd_d = fix_bcd;
        acc_d = sh_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bin_d   = sh_acc;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Testbench for bcd2binary_seq.
// Vector table, random requests and multi-cycle corner sequences.
module tb_bcd2binary_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       bcd_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  bin_out;

  int tests;
  int fails;

  logic [BIN_W-1:0] last_bin;
  logic             last_err;

  typedef struct {
    logic [15:0]      bcd;
    logic [BIN_W-1:0] bin;
    logic             err;
  } vec_t;

  vec_t vecs[10];

  bcd2binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: decimal value of the digits, or error if any digit > 9.
  function automatic void model(input logic [15:0] b,
                                output logic [BIN_W-1:0] v,
                                output logic e);
    int acc;
    logic [3:0] nib;
    acc = 0;
    e = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = b[4*i +: 4];
      if (nib > 4'd9) e = 1'b1;
      acc = acc * 10 + int'(nib);
    end
    v = e ? '0 : acc[BIN_W-1:0];
  endfunction

  // One request: start at negedge, T0 at next posedge, follow to done.
  task automatic run_req(input string name, input logic [15:0] b,
                         input logic [BIN_W-1:0] eb, input logic ee);
    int k;
    int lat;
    int hold_bad;
    int exp_lat;
    hold_bad = 0;
    lat = 0;
    exp_lat = ee ? 1 : BIN_W + 1;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(posedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 16'(~b);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || bin_out !== last_bin || err !== last_err)
        hold_bad++;
    end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " bin_out"}, 32'(bin_out), 32'(eb));
    chk({name, " err"}, 32'(err), 32'(ee));
    chk({name, " hold/busy"}, hold_bad, 0);
    last_bin = eb;
    last_err = ee;
    @(negedge clk);
    chk({name, " pulse end"}, {busy, done}, 0);
  endtask

  initial begin
    logic [BIN_W-1:0] eb;
    logic             ee;
    logic [15:0]      rb;
    int               dpos[$];
    int               dbad;
    int               dcnt;

    tests = 0;
    fails = 0;
    last_bin = '0;
    last_err = 1'b0;

    vecs[0] = '{16'h1234, 14'd1234, 1'b0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0};
    vecs[3] = '{16'h12A4, 14'd0,    1'b1};
    vecs[4] = '{16'h0042, 14'd42,   1'b0};
    vecs[5] = '{16'h0001, 14'd1,    1'b0};
    vecs[6] = '{16'h0500, 14'd500,  1'b0};
    vecs[7] = '{16'hF000, 14'd0,    1'b1};
    vecs[8] = '{16'h8000, 14'd8000, 1'b0};
    vecs[9] = '{16'h0009, 14'd9,    1'b0};

    rst    = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset outs", {busy, done, err, 18'(bin_out)}, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_req($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err);

    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(9) == 0)
          rb[4*d +: 4] = 4'($urandom_range(15, 10));
        else
          rb[4*d +: 4] = 4'($urandom_range(9));
      end
      model(rb, eb, ee);
      run_req($sformatf("rnd%0d", i), rb, eb, ee);
    end

    // Re-pulsed start and operand change mid-conversion.
    dcnt = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h1234;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start  = (k == 5);
      bcd_in = (k >= 5) ? 16'h9999 : 16'h1234;
      if (done) begin
        dcnt++;
        chk("restart lat", k, BIN_W + 1);
        chk("restart bin", 32'(bin_out), 1234);
      end
    end
    chk("restart pulses", dcnt, 1);
    last_bin = 14'd1234;
    last_err = 1'b0;

    // Reset in the middle of a conversion.
    dcnt = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0777;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst outs", {busy, done, err, 18'(bin_out)}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("post rst quiet", dcnt, 0);
    last_bin = '0;
    last_err = 1'b0;
    run_req("after rst", 16'h0042, 14'd42, 1'b0);

    // Start held high: back-to-back conversions.
    dbad = 0;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0500;
    @(posedge clk);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (done) begin
        dpos.push_back(k);
        if (bin_out !== 14'd500 || err !== 1'b0) dbad++;
      end
    end
    start = 1'b0;
    chk("b2b pulses", dpos.size(), 3);
    chk("b2b values", dbad, 0);
    if (dpos.size() == 3) begin
      chk("b2b first", dpos[0], BIN_W + 1);
      chk("b2b gap1", dpos[1] - dpos[0], 16);
      chk("b2b gap2", dpos[2] - dpos[1], 16);
    end
    repeat (2) @(negedge clk);
    chk("b2b idle", {busy, done}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
